// File: rtl/watch_pkg.sv
// Shared watch definitions: key codes, entry FSM states and the HH:MM validity check.
// Pure declarations, no latency; no flow control involved.
package watch_pkg;

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;

  typedef enum logic {
    IDLE,
    ENTRY
  } entry_state_t;

  // Digits arrive as BCD 0-9, so only the tens positions can go out of range.
  function automatic logic valid_hhmm(input logic [3:0] ms_hr,
                                     input logic [3:0] ls_hr,
                                     input logic [3:0] ms_min,
                                     input logic [3:0] ls_min);
    logic ok;
    ok = (ms_hr <= 4'd2) && (ls_hr <= 4'd9) && (ms_min <= 4'd5) && (ls_min <= 4'd9);
    if (ms_hr == 4'd2 && ls_hr > 4'd3) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/key_timeout_timer.sv
// Counts one_second strobes while enabled; timeout pulses combinationally on the strobe reaching TIMEOUT_SEC.
// Zero-cycle timeout decision, count updates next edge; no backpressure, strobes are never held off.
module key_timeout_timer #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic timeout
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_SEC);

  logic [TW-1:0] cnt_q, cnt_d;

  // Saturates at LIMIT so the count can never wrap back into range.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && one_second && cnt_q != LIMIT) begin
      cnt_d   = cnt_q + TW'(1);
      timeout = (cnt_d == LIMIT);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_key_entry.sv
// Keypad HH:MM entry: shifts digits, validates on ALARM/TIME, pulses load or error; abandons on inactivity.
// One-cycle latency from key strobe to registered outputs; no backpressure, every key strobe is consumed.
module alarm_key_entry
  import watch_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_alarm,
  output logic       load_new_time,
  output logic       show_new_time,
  output logic       entry_error
);

  entry_state_t state_q;
  logic [3:0]   ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
  logic         load_alarm_q, load_time_q, show_q, error_q;

  logic is_digit, is_cmd, timeout;

  assign is_digit = key_valid && (key <= 4'd9);
  assign is_cmd   = key_valid && (key == KEY_ALARM || key == KEY_TIME);

  // Codes 12-15 count as no key, so they neither clear nor stall the timer.
  key_timeout_timer #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (is_digit),
    .enable    ((state_q == ENTRY) && !is_cmd),
    .one_second(one_second),
    .timeout   (timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      ms_hr_q      <= '0;
      ls_hr_q      <= '0;
      ms_min_q     <= '0;
      ls_min_q     <= '0;
      load_alarm_q <= 1'b0;
      load_time_q  <= 1'b0;
      show_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      load_alarm_q <= 1'b0;
      load_time_q  <= 1'b0;
      error_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_digit) begin
            ms_hr_q  <= '0;
            ls_hr_q  <= '0;
            ms_min_q <= '0;
            ls_min_q <= key;
            state_q  <= ENTRY;
            show_q   <= 1'b1;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            ms_hr_q  <= ls_hr_q;
            ls_hr_q  <= ms_min_q;
            ms_min_q <= ls_min_q;
            ls_min_q <= key;
          end else if (is_cmd) begin
            // The buffer is left intact so the loaded digits stay on the bus.
            if (valid_hhmm(ms_hr_q, ls_hr_q, ms_min_q, ls_min_q)) begin
              load_alarm_q <= (key == KEY_ALARM);
              load_time_q  <= (key == KEY_TIME);
            end else begin
              error_q <= 1'b1;
            end
            state_q <= IDLE;
            show_q  <= 1'b0;
          end else if (timeout) begin
            ms_hr_q  <= '0;
            ls_hr_q  <= '0;
            ms_min_q <= '0;
            ls_min_q <= '0;
            state_q  <= IDLE;
            show_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          show_q  <= 1'b0;
        end
      endcase
    end
  end

  assign new_alarm_ms_hr  = ms_hr_q;
  assign new_alarm_ls_hr  = ls_hr_q;
  assign new_alarm_ms_min = ms_min_q;
  assign new_alarm_ls_min = ls_min_q;
  assign load_new_alarm   = load_alarm_q;
  assign load_new_time    = load_time_q;
  assign show_new_time    = show_q;
  assign entry_error      = error_q;

endmodule

// File: tb/tb_alarm_key_entry.sv
// Scoreboard bench for alarm_key_entry: arithmetic reference model feeds an expectation queue.
// A negedge monitor pops and compares the full output snapshot each cycle.
module tb_alarm_key_entry;

  localparam int TO = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_alarm, load_new_time, show_new_time, entry_error;

  alarm_key_entry #(.TIMEOUT_SEC(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .one_second      (one_second),
    .key_valid       (key_valid),
    .key             (key),
    .new_alarm_ms_hr (ms_hr),
    .new_alarm_ls_hr (ls_hr),
    .new_alarm_ms_min(ms_min),
    .new_alarm_ls_min(ls_min),
    .load_new_alarm  (load_new_alarm),
    .load_new_time   (load_new_time),
    .show_new_time   (show_new_time),
    .entry_error     (entry_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [19:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: the entry is an integer 0..9999 read as HHMM.
  bit m_in   = 0;
  int m_val  = 0;
  int m_secs = 0;

  function automatic logic [19:0] model_step(input logic r, input logic kv,
                                             input logic [3:0] k, input logic os);
    logic la, lt, er;
    bit   digit, cmd;
    la = 0; lt = 0; er = 0;
    digit = kv && (k <= 9);
    cmd   = kv && (k == 10 || k == 11);
    if (!r) begin
      m_in = 0; m_val = 0; m_secs = 0;
    end else if (!m_in) begin
      if (digit) begin
        m_val = int'(k); m_in = 1; m_secs = 0;
      end
    end else if (digit) begin
      m_val  = (m_val * 10 + int'(k)) % 10000;
      m_secs = 0;
    end else if (cmd) begin
      if (m_val / 100 <= 23 && m_val % 100 <= 59) begin
        if (k == 10) la = 1; else lt = 1;
      end else begin
        er = 1;
      end
      m_in = 0;
    end else if (os) begin
      m_secs++;
      if (m_secs == TO) begin
        m_in = 0; m_val = 0;
      end
    end
    return {4'(m_val / 1000), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10),
            4'(m_val % 10), la, lt, logic'(m_in), er};
  endfunction

  task automatic tick(input logic r, input logic kv, input logic [3:0] k, input logic os);
    exp_t e;
    reset = r; key_valid = kv; key = k; one_second = os;
    e.due = cyc + 1;
    e.exp = model_step(r, kv, k, os);
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    tick(1, 1, k, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 4'd0, 0);
  endtask

  task automatic sec();
    tick(1, 0, 4'd0, 1);
    idle(2);
  endtask

  always @(negedge clock) begin : monitor
    exp_t        e;
    logic [19:0] act;
    act = {ms_hr, ls_hr, ms_min, ls_min, load_new_alarm, load_new_time,
           show_new_time, entry_error};
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL outputs cyc=%0d actual=%h expected=%h (digits,la,lt,show,err)",
                 cyc, act, e.exp);
      end
    end
  end

  initial begin
    logic       r, kv, os;
    logic [3:0] k;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) tick(0, 0, 4'd0, 0);
    idle(2);

    press(1); press(2); press(3); press(4); press(4'd10); idle(2);
    press(2); press(4); press(0); press(0); press(4'd11); idle(2);
    press(7); press(5); press(4'd10); idle(1);
    press(5); press(9); press(4'd11); idle(2);
    press(9);
    for (int i = 0; i < TO; i++) sec();
    idle(2);
    press(9);
    for (int i = 0; i < TO - 2; i++) sec();
    tick(1, 1, 4'd3, 1);
    for (int i = 0; i < TO; i++) sec();
    idle(2);
    for (int d = 1; d <= 6; d++) press(4'(d));
    press(4'd10); idle(2);
    press(1); press(2); tick(0, 0, 4'd0, 0); press(4'd10); idle(2);
    press(4'd12); press(2); press(4'd15); press(3); press(4'd13); press(4'd11); idle(1);
    press(4'd10); press(4'd11); idle(1);

    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      kv = (i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)      k = 4'($urandom_range(10, 15));
      else if ($urandom_range(0, 1) == 0) k = 4'($urandom_range(0, 2));
      else                                k = 4'($urandom_range(0, 9));
      os = (i < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      if (kv && k >= 12) os = 0;
      tick(r, kv, k, os);
    end
    idle(2);

    @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
